// File: rtl/ddc_srio_pkt.sv
// Packs DDC I/Q samples into 64-bit words, buffers them in a 64-deep FIFO and
// streams them to an SRIO initiator port as 32-beat NWRITE packets with a HELLO header.
module ddc_srio_pkt #(
  parameter logic [15:0] DEST_ID   = 16'h00FF,
  parameter logic [15:0] SRC_ID    = 16'h0001,
  parameter logic [33:0] BASE_ADDR = 34'h0_0C00_0000,
  parameter int          WIN_PKTS  = 1024
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic        en,
  input  logic [15:0] ddc_i,
  input  logic [15:0] ddc_q,
  input  logic        ddc_valid,
  output logic        ireq_tvalid,
  input  logic        ireq_tready,
  output logic [63:0] ireq_tdata,
  output logic [7:0]  ireq_tkeep,
  output logic        ireq_tlast,
  output logic [31:0] ireq_tuser,
  output logic        ovf,
  output logic [31:0] pkt_cnt
);

  localparam int IDX_W = (WIN_PKTS > 1) ? $clog2(WIN_PKTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN_PKTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_half;
  logic [31:0]        r_hold;
  logic [63:0]        r_word;
  logic               r_push;
  logic [63:0]        r_mem [64];
  logic [5:0]         r_wptr, r_rptr;
  logic [6:0]         r_cnt;
  logic               r_ovf;
  logic [4:0]         r_beat;
  logic [7:0]         r_tid;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_pkt_cnt;

  logic               w_pop, w_full, w_wr, w_drop, w_last_hs;
  logic [6:0]         w_cnt_nxt;
  logic [33:0]        w_addr;
  logic [63:0]        w_hdr;

  // Pair up samples; en low throws away a lone first half.
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      r_half <= 1'b0;
      r_hold <= '0;
      r_word <= '0;
      r_push <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (!en) begin
        r_half <= 1'b0;
      end else if (ddc_valid) begin
        if (!r_half) begin
          r_hold <= {ddc_i, ddc_q};
          r_half <= 1'b1;
        end else begin
          r_word <= {r_hold, ddc_i, ddc_q};
          r_push <= 1'b1;
          r_half <= 1'b0;
        end
      end
    end
  end

  assign w_pop     = (r_state == S_DATA) && ireq_tready;
  assign w_full    = (r_cnt == 7'd64);
  assign w_wr      = r_push && (!w_full || w_pop);
  assign w_drop    = r_push && w_full && !w_pop;
  assign w_cnt_nxt = r_cnt + {6'd0, w_wr} - {6'd0, w_pop};
  assign w_last_hs = w_pop && (r_beat == 5'd31);

  always_ff @(posedge log_clk) begin
    if (w_wr && !log_rst) r_mem[r_wptr] <= r_word;
  end

  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)   r_wptr <= r_wptr + 6'd1;
      if (w_pop)  r_rptr <= r_rptr + 6'd1;
      r_cnt <= w_cnt_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en && (r_cnt >= 7'd32)) w_state_nxt = S_HDR;
      S_HDR:  if (ireq_tready) w_state_nxt = S_DATA;
      S_DATA: if (w_last_hs)
                w_state_nxt = (en && (w_cnt_nxt >= 7'd32)) ? S_HDR : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_tid     <= '0;
      r_idx     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_HDR) && ireq_tready) r_beat <= '0;
      else if (w_pop)                        r_beat <= r_beat + 5'd1;
      if (w_last_hs) begin
        r_tid     <= r_tid + 8'd1;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  end

  assign w_addr = BASE_ADDR + (34'(r_idx) << 8);
  assign w_hdr  = {r_tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'hFF, 2'b00, w_addr};

  // Outputs decode straight from held state, so they stay put under backpressure.
  always_comb begin
    ireq_tdata = '0;
    case (r_state)
      S_HDR:   ireq_tdata = w_hdr;
      S_DATA:  ireq_tdata = r_mem[r_rptr];
      default: ireq_tdata = '0;
    endcase
  end

  assign ireq_tvalid = (r_state != S_IDLE);
  assign ireq_tlast  = (r_state == S_DATA) && (r_beat == 5'd31);
  assign ireq_tkeep  = 8'hFF;
  assign ireq_tuser  = {SRC_ID, DEST_ID};
  assign ovf         = r_ovf;
  assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_ddc_srio_pkt.sv
// Directed bench for ddc_srio_pkt: table of streaming scenarios plus hand-written
// en-drop and mid-packet reset sequences; an AXIS monitor logs handshakes and checks stall stability.
module tb_ddc_srio_pkt;

  localparam int M_ON = 0, M_OFF = 1, M_TOG = 2;
  localparam logic [33:0] BASE = 34'h0_0C00_0000;
  localparam logic [33:0] A1   = 34'h0_0C00_0100;

  logic        log_clk = 1'b0, log_rst = 1'b1, en = 1'b0, ddc_valid = 1'b0, ireq_tready = 1'b0;
  logic [15:0] ddc_i = '0, ddc_q = '0;
  logic        ireq_tvalid, ireq_tlast, ovf;
  logic [63:0] ireq_tdata;
  logic [7:0]  ireq_tkeep;
  logic [31:0] ireq_tuser, pkt_cnt;

  ddc_srio_pkt #(.WIN_PKTS(2)) dut (
    .log_clk(log_clk), .log_rst(log_rst), .en(en), .ddc_i(ddc_i), .ddc_q(ddc_q),
    .ddc_valid(ddc_valid), .ireq_tvalid(ireq_tvalid), .ireq_tready(ireq_tready),
    .ireq_tdata(ireq_tdata), .ireq_tkeep(ireq_tkeep), .ireq_tlast(ireq_tlast),
    .ireq_tuser(ireq_tuser), .ovf(ovf), .pkt_cnt(pkt_cnt)
  );

  always #5 log_clk = ~log_clk;

  typedef struct {
    logic [63:0] d;
    logic        l;
    int          cyc;
  } cap_t;

  typedef struct {
    int              nsamp;
    int              mode;
    int              npkt;
    logic            ovf;
    logic [2:0][7:0]  tid;
    logic [2:0][33:0] addr;
    logic [2:0][31:0] smp0;
  } vec_t;

  cap_t cap[$];
  vec_t tbl[4];
  int   n_cmp = 0, n_bad = 0, cyc = 0, mode = M_OFF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int s);
    logic [15:0] a, b;
    a = 16'(s);
    b = 16'(s + 1);
    return {a, ~a, b, ~b};
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [7:0] tid, input logic [33:0] a);
    return {tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'hFF, 2'b00, a};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge log_clk);
    #1;
  endtask

  task automatic wait_cap(input int n, input int budget);
    int c = 0;
    while (cap.size() < n && c < budget) begin
      wait_cyc(1);
      c++;
    end
    n_cmp++;
    if (cap.size() < n) begin
      n_bad++;
      $display("FAIL wait_cap: got %0d beats expected %0d", cap.size(), n);
    end
  endtask

  task automatic send(input int s, input int cnt);
    for (int n = s; n < s + cnt; n++) begin
      ddc_i = 16'(n);
      ddc_q = ~16'(n);
      ddc_valid = 1'b1;
      wait_cyc(1);
    end
    ddc_valid = 1'b0;
  endtask

  task automatic do_reset();
    log_rst = 1'b1;
    wait_cyc(2);
    log_rst = 1'b0;
    cap.delete();
  endtask

  task automatic check_pkt(input int b, input logic [7:0] tid, input logic [33:0] a, input int s);
    if (cap.size() < b + 33) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pkt_short: got %0d beats expected %0d", cap.size(), b + 33);
    end else begin
      chk("hdr", cap[b].d, mk_hdr(tid, a));
      chk("hdr_last", 64'(cap[b].l), 64'd0);
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("beat%0d", i), cap[b+1+i].d, exp_word(s + 2 * i));
        chk($sformatf("last%0d", i), 64'(cap[b+1+i].l), 64'(i == 31));
      end
    end
  endtask

  initial forever begin
    @(posedge log_clk);
    cyc++;
  end

  // Ready pattern driver
  initial forever begin
    @(posedge log_clk);
    #1;
    case (mode)
      M_ON:    ireq_tready = 1'b1;
      M_OFF:   ireq_tready = 1'b0;
      default: ireq_tready = ~ireq_tready;
    endcase
  end

  // Handshake logger and stall-stability checker
  initial begin
    logic        st_prev;
    logic [63:0] st_d;
    logic        st_l;
    st_prev = 1'b0;
    st_d = '0;
    st_l = 1'b0;
    forever begin
      @(negedge log_clk);
      if (ireq_tvalid && ireq_tready) cap.push_back('{ireq_tdata, ireq_tlast, cyc});
      if (st_prev) begin
        chk("stall_valid", 64'(ireq_tvalid), 64'd1);
        chk("stall_data", ireq_tdata, st_d);
        chk("stall_last", 64'(ireq_tlast), 64'(st_l));
      end
      st_prev = ireq_tvalid && !ireq_tready && !log_rst;
      st_d    = ireq_tdata;
      st_l    = ireq_tlast;
    end
  end

  initial begin
    tbl[0] = '{64,  M_ON,  1, 1'b0, {8'd0, 8'd0, 8'd0}, {34'd0, 34'd0, BASE},
               {32'd0, 32'd0, 32'd0}};
    tbl[1] = '{128, M_TOG, 2, 1'b0, {8'd0, 8'd1, 8'd0}, {34'd0, A1, BASE},
               {32'd0, 32'd64, 32'd0}};
    tbl[2] = '{130, M_OFF, 2, 1'b1, {8'd0, 8'd1, 8'd0}, {34'd0, A1, BASE},
               {32'd0, 32'd64, 32'd0}};
    tbl[3] = '{192, M_ON,  3, 1'b0, {8'd2, 8'd1, 8'd0}, {BASE, A1, BASE},
               {32'd128, 32'd64, 32'd0}};

    do_reset();
    chk("rst_tvalid", 64'(ireq_tvalid), 64'd0);
    chk("rst_tlast", 64'(ireq_tlast), 64'd0);
    chk("rst_tdata", ireq_tdata, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_tkeep", 64'(ireq_tkeep), 64'hFF);
    chk("rst_tuser", 64'(ireq_tuser), 64'h0001_00FF);

    for (int k = 0; k < 4; k++) begin
      do_reset();
      mode = tbl[k].mode;
      en = 1'b1;
      send(0, tbl[k].nsamp);
      wait_cyc(4);
      if (tbl[k].mode == M_OFF) begin
        chk("full_ovf", 64'(ovf), 64'(tbl[k].ovf));
        chk("full_tvalid", 64'(ireq_tvalid), 64'd1);
        chk("full_hdr_held", ireq_tdata, mk_hdr(8'd0, BASE));
        mode = M_ON;
      end
      wait_cap(33 * tbl[k].npkt, 3000);
      wait_cyc(10);
      for (int p = 0; p < tbl[k].npkt; p++)
        check_pkt(33 * p, tbl[k].tid[p], tbl[k].addr[p], int'(tbl[k].smp0[p]));
      if (k == 0 && cap.size() >= 33) begin
        chk("t1_hdr_lit", cap[0].d, 64'h0054_2FF0_0C00_0000);
        chk("t1_beat0_lit", cap[1].d, 64'h0000_FFFF_0001_FFFE);
        chk("t1_no_gaps", 64'(cap[32].cyc - cap[0].cyc), 64'd32);
      end
      chk($sformatf("v%0d_pkt_cnt", k), 64'(pkt_cnt), 64'(tbl[k].npkt));
      chk($sformatf("v%0d_ovf", k), 64'(ovf), 64'(tbl[k].ovf));
      chk($sformatf("v%0d_idle", k), 64'(ireq_tvalid), 64'd0);
    end

    // en drops mid-packet with a lone sample pending in the pack register
    do_reset();
    mode = M_ON;
    en = 1'b1;
    send(0, 65);
    wait_cap(11, 500);
    en = 1'b0;
    wait_cap(33, 500);
    wait_cyc(5);
    check_pkt(0, 8'd0, BASE, 0);
    chk("endrop_idle", 64'(ireq_tvalid), 64'd0);
    chk("endrop_pkt_cnt", 64'(pkt_cnt), 64'd1);
    send(200, 4);
    en = 1'b1;
    send(100, 64);
    wait_cap(66, 500);
    wait_cyc(5);
    check_pkt(33, 8'd1, A1, 100);
    chk("endrop_pkt_cnt2", 64'(pkt_cnt), 64'd2);

    // reset pulse at data beat 20
    do_reset();
    mode = M_ON;
    en = 1'b1;
    send(0, 64);
    wait_cap(21, 500);
    log_rst = 1'b1;
    wait_cyc(1);
    log_rst = 1'b0;
    @(negedge log_clk);
    chk("rstmid_tvalid", 64'(ireq_tvalid), 64'd0);
    chk("rstmid_tdata", ireq_tdata, 64'd0);
    chk("rstmid_pkt_cnt", 64'(pkt_cnt), 64'd0);
    begin
      int nl = 0;
      foreach (cap[i]) if (cap[i].l) nl++;
      chk("rstmid_no_tlast", 64'(nl), 64'd0);
    end
    wait_cyc(1);
    cap.delete();
    send(300, 64);
    wait_cap(33, 500);
    wait_cyc(5);
    check_pkt(0, 8'd0, BASE, 300);
    chk("rstmid_pkt_cnt2", 64'(pkt_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
